// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter sharing one 4:1 data mux among four
// requesters. A grant lasts while its owner holds req. When the owner lets go,
// the grant passes to the next pending requester after it, on the same edge.
// Optional feature macro: MUX_ARB_HOLD_LIMIT_EN. When it is defined, a tenure is
// capped at HOLD_MAX cycles. The owner is then forced to release and drops to
// lowest priority.
module mux4_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] d,
  output logic [3:0]         grant,
  output logic [1:0]         select,
  output logic               valid,
  output logic [WIDTH-1:0]   q
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Reject meaningless configurations at elaboration time.
  if (WIDTH < 1 || HOLD_MAX < 1) begin : g_param_check
    $error("mux4_rr_arbiter: WIDTH and HOLD_MAX must be >= 1");
  end

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] select_q, select_d;
  logic       valid_q, valid_d;
  logic [1:0] ptr_q, ptr_d;
  logic [2:0] pick;
  logic       rel;

`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
  logic [HW-1:0] hold_q, hold_d;
`endif

  // Returns {found, index}: the first requester with req set, scanning from p upward mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [2:0] res;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Next-state logic: arbitrate from IDLE, hold or hand over the grant from GRANT.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    select_d = select_q;
    valid_d  = valid_q;
    ptr_d    = ptr_q;
    pick     = 3'b000;
    rel      = 1'b0;
`ifdef MUX_ARB_HOLD_LIMIT_EN
    hold_d   = hold_q;
`endif
    case (state_q)
      IDLE: begin
        pick = rr_pick(req, ptr_q);
        if (pick[2]) begin
          state_d  = GRANT;
          grant_d  = 4'b0001 << pick[1:0];
          select_d = pick[1:0];
          valid_d  = 1'b1;
`ifdef MUX_ARB_HOLD_LIMIT_EN
          hold_d   = '0;
`endif
        end
      end
      GRANT: begin
        rel = !req[select_q];
`ifdef MUX_ARB_HOLD_LIMIT_EN
        // A tenure that reaches its last allowed cycle ends, even if req is still held.
        rel = rel || (hold_q == HOLD_LAST);
`endif
        if (rel) begin
          // The owner now has the lowest priority, so a sole requester gets the grant again.
          ptr_d = select_q + 2'd1;
          pick  = rr_pick(req, select_q + 2'd1);
          if (pick[2]) begin
            grant_d  = 4'b0001 << pick[1:0];
            select_d = pick[1:0];
            valid_d  = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = 4'b0000;
            valid_d = 1'b0;
          end
`ifdef MUX_ARB_HOLD_LIMIT_EN
          hold_d = '0;
`endif
        end else begin
`ifdef MUX_ARB_HOLD_LIMIT_EN
          hold_d = hold_q + HW'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset takes precedence over every other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= 4'b0000;
      select_q <= 2'd0;
      valid_q  <= 1'b0;
      ptr_q    <= 2'd0;
`ifdef MUX_ARB_HOLD_LIMIT_EN
      hold_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      select_q <= select_d;
      valid_q  <= valid_d;
      ptr_q    <= ptr_d;
`ifdef MUX_ARB_HOLD_LIMIT_EN
      hold_q   <= hold_d;
`endif
    end
  end

  // Output mux: live data of the granted requester, and zero when there is no grant.
  always_comb begin
    q = '0;
    for (int i = 0; i < 4; i++) begin
      if (valid_q && (select_q == 2'(i))) q = d[i*WIDTH +: WIDTH];
    end
  end

  assign grant  = grant_q;
  assign select = select_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter (WIDTH=8). The hold-limit scenario is
// compiled only when MUX_ARB_HOLD_LIMIT_EN is defined, and then HOLD_MAX=3.
module tb_mux4_rr_arbiter;

  localparam int WIDTH = 8;
`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam int HOLD_MAX = 3;
`else
  localparam int HOLD_MAX = 8;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic [3:0]         req;
  logic [4*WIDTH-1:0] d;
  logic [3:0]         grant;
  logic [1:0]         select;
  logic               valid;
  logic [WIDTH-1:0]   q;

  int checks = 0;
  int errors = 0;

  mux4_rr_arbiter #(.WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .d      (d),
    .grant  (grant),
    .select (select),
    .valid  (valid),
    .q      (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge, where outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic [3:0] g, input logic v);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".valid"}, 32'(valid), 32'(v));
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    d     = {8'h3C, 8'hA5, 8'h5A, 8'h11};
    tick();
    tick();
    reset = 1'b0;
    check_grant("rst", 4'b0000, 1'b0);
    check("rst.select", 32'(select), 32'd0);
    check("rst.q", 32'(q), 32'h0);

    // A single request from IDLE is granted on the next edge.
    req = 4'b0100;
    #1;
    check_grant("idle_pre", 4'b0000, 1'b0);
    tick();
    check_grant("t2", 4'b0100, 1'b1);
    check("t2.select", 32'(select), 32'd2);
    check("t2.q", 32'(q), 32'hA5);
    d[2*WIDTH +: WIDTH] = 8'h77;
    #1;
    check("q_live", 32'(q), 32'h77);
    d[2*WIDTH +: WIDTH] = 8'hA5;

    // Reset asserted in the middle of a grant.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    req   = 4'b0000;
    check_grant("t1", 4'b0000, 1'b0);
    check("t1.select", 32'(select), 32'd0);
    check("t1.q", 32'(q), 32'h0);
    tick();
    check_grant("idle_stay", 4'b0000, 1'b0);

    // All requesters active, each owner lets go after two cycles: grant order 0,1,2,3,0.
    req = 4'b1111;
    tick();
    check_grant("rr0.c1", 4'b0001, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_grant($sformatf("rr%0d.c2", k), 4'b0001 << k, 1'b1);
      req = 4'b1111 & ~(4'b0001 << k);
      tick();
      check_grant($sformatf("rr%0d.next", k), 4'b0001 << ((k + 1) % 4), 1'b1);
      check($sformatf("rr%0d.sel", k), 32'(select), 32'((k + 1) % 4));
      req = 4'b1111;
    end
    // Owner 0 lets go with nothing else pending, so the grant ends. ptr is now 1.
    req = 4'b0000;
    tick();
    check_grant("rr_idle", 4'b0000, 1'b0);
    check("rr_idle.q", 32'(q), 32'h0);

    // Owner 1 drops in the same cycle that req[3] rises.
    req = 4'b0010;
    tick();
    check_grant("t4.own", 4'b0010, 1'b1);
    check("t4.q1", 32'(q), 32'h5A);
    req = 4'b1000;
    tick();
    check_grant("t4.swap", 4'b1000, 1'b1);
    check("t4.select", 32'(select), 32'd3);
    check("t4.q3", 32'(q), 32'h3C);
    req = 4'b0000;
    tick();
    check_grant("t4.idle", 4'b0000, 1'b0);
    check("t4.sel_hold", 32'(select), 32'd3);

    // A new request does not preempt the current owner. ptr has wrapped to 0.
    req = 4'b0001;
    tick();
    check_grant("t5.own", 4'b0001, 1'b1);
    req = 4'b0101;
    tick();
    check_grant("t5.wait1", 4'b0001, 1'b1);
    tick();
    check_grant("t5.wait2", 4'b0001, 1'b1);
    req = 4'b0100;
    tick();
    check_grant("t5.next", 4'b0100, 1'b1);
    check("t5.select", 32'(select), 32'd2);
    check("t5.q", 32'(q), 32'hA5);
    req = 4'b0000;
    tick();
    check_grant("t5.idle", 4'b0000, 1'b0);

`ifdef MUX_ARB_HOLD_LIMIT_EN
    // Capped tenure of 3 cycles: two requesters alternate, and a sole requester keeps the grant.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b0011;
    for (int c = 0; c < 9; c++) begin
      tick();
      check_grant($sformatf("t6.alt%0d", c), (c / 3) % 2 == 0 ? 4'b0001 : 4'b0010, 1'b1);
    end
    // The last forced release gave the grant back to 0, and owner 0 has been in tenure for 2 cycles.
    req = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      tick();
      check_grant($sformatf("t6.sole%0d", c), 4'b0001, 1'b1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
